// File: rtl/stoch_add_if.sv
// Bus between the stochastic-adder sequencer (slave) and its run controller,
// external adder and result consumer (master).
interface stoch_add_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [7:0]       a_val;
  logic [7:0]       b_val;
  logic             busy;
  logic             a;
  logic             b;
  logic             rand_bit;
  logic             y;
  logic [CNT_W-1:0] ones_count;
  logic             result_valid;
  logic             result_ready;
  logic             mismatch;
  logic [CNT_W-1:0] mismatch_count;

  modport slave (
    input  start, a_val, b_val, y, result_ready,
    output busy, a, b, rand_bit, ones_count, result_valid, mismatch, mismatch_count
  );

  modport master (
    output start, a_val, b_val, y, result_ready,
    input  busy, a, b, rand_bit, ones_count, result_valid, mismatch, mismatch_count
  );
endinterface

// File: rtl/stoch_add_sequencer.sv
// Drives an external stochastic mux-adder with LFSR-generated bitstreams and counts its 1s.
// Optional adder self-check enabled by defining STOCH_ADDER_CHECK_EN.
module stoch_add_sequencer #(
  parameter int unsigned BIT_LENGTH = 128,
  parameter logic [7:0]  SEED_A     = 8'hA5,
  parameter logic [7:0]  SEED_B     = 8'h3C,
  parameter logic [7:0]  SEED_S     = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  stoch_add_if.slave  bus
);
  localparam int CNT_W = $clog2(BIT_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_LENGTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(BIT_LENGTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] ones_q;
  logic [7:0]       lfsr_a, lfsr_b, lfsr_s;
  logic [7:0]       a_cap, b_cap;
  logic             start_run;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign start_run = (state == IDLE) && bus.start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)             state_next = RUN;
      RUN:     if (bit_cnt == LAST_BIT)   state_next = DONE;
      DONE:    if (bus.result_ready)      state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
      lfsr_s  <= SEED_S;
      a_cap   <= '0;
      b_cap   <= '0;
      bit_cnt <= '0;
      ones_q  <= '0;
    end else if (start_run) begin
      lfsr_a  <= SEED_A;
      lfsr_b  <= SEED_B;
      lfsr_s  <= SEED_S;
      a_cap   <= bus.a_val;
      b_cap   <= bus.b_val;
      bit_cnt <= '0;
      ones_q  <= '0;
    end else if (state == RUN) begin
      // LFSRs advance only after this cycle's bits have been presented to the adder.
      lfsr_a  <= lfsr_step(lfsr_a);
      lfsr_b  <= lfsr_step(lfsr_b);
      lfsr_s  <= lfsr_step(lfsr_s);
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (bus.y && ones_q != MAX_CNT) ones_q <= ones_q + CNT_W'(1);
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.a            = (state == RUN) && (lfsr_a < a_cap);
  assign bus.b            = (state == RUN) && (lfsr_b < b_cap);
  assign bus.rand_bit     = (state == RUN) && (lfsr_s < 8'd128);
  assign bus.ones_count   = ones_q;

`ifdef STOCH_ADDER_CHECK_EN
  logic             mismatch_q;
  logic [CNT_W-1:0] mm_cnt_q;
  logic             expected_y;

  assign expected_y = bus.rand_bit ? bus.b : bus.a;

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      mismatch_q <= 1'b0;
      mm_cnt_q   <= '0;
    end else if (state == RUN && bus.y != expected_y) begin
      mismatch_q <= 1'b1;
      if (mm_cnt_q != MAX_CNT) mm_cnt_q <= mm_cnt_q + CNT_W'(1);
    end
  end

  assign bus.mismatch       = mismatch_q;
  assign bus.mismatch_count = mm_cnt_q;
`else
  assign bus.mismatch       = 1'b0;
  assign bus.mismatch_count = '0;
`endif
endmodule

// File: tb/tb_stoch_add_sequencer.sv
// Randomized self-checking bench for stoch_add_sequencer against a cycle-indexed
// bitstream model; honours STOCH_ADDER_CHECK_EN like the design.
module tb_stoch_add_sequencer;
  localparam int BL = 128;
  localparam int CW = $clog2(BL + 1);
  localparam logic [7:0] SA = 8'hA5;
  localparam logic [7:0] SB = 8'h3C;
  localparam logic [7:0] SS = 8'h5A;
`ifdef STOCH_ADDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   fault = 0;   // 0 = correct mux adder, 1 = y stuck at 1, 2 = OR gate
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  stoch_add_if #(.CNT_W(CW)) bus ();

  stoch_add_sequencer #(
    .BIT_LENGTH(BL), .SEED_A(SA), .SEED_B(SB), .SEED_S(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.y = (fault == 1) ? 1'b1 :
                 (fault == 2) ? (bus.a | bus.b) :
                 (bus.rand_bit ? bus.b : bus.a);

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the three bitstreams as value sequences indexed by bit position.
  logic [7:0] seq_a [BL];
  logic [7:0] seq_b [BL];
  logic [7:0] seq_s [BL];

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  int         pos = -1;   // -1 idle, 0..BL-1 current bit index, BL result held
  logic [7:0] cap_a, cap_b;
  int         m_ones = 0;
  int         m_mmc = 0;
  bit         m_mm = 1'b0;

  function automatic bit m_a();
    return (pos >= 0 && pos < BL) && (seq_a[pos] < cap_a);
  endfunction
  function automatic bit m_b();
    return (pos >= 0 && pos < BL) && (seq_b[pos] < cap_b);
  endfunction
  function automatic bit m_r();
    return (pos >= 0 && pos < BL) && (seq_s[pos] < 8'd128);
  endfunction

  always @(posedge clk) begin : model
    bit ya, yb, ys, yy;
    if (rst) begin
      pos = -1; m_ones = 0; m_mm = 1'b0; m_mmc = 0;
    end else if (pos < 0) begin
      if (bus.start) begin
        pos = 0; cap_a = bus.a_val; cap_b = bus.b_val;
        m_ones = 0; m_mm = 1'b0; m_mmc = 0;
      end
    end else if (pos < BL) begin
      ya = m_a(); yb = m_b(); ys = m_r();
      yy = (fault == 1) ? 1'b1 : (fault == 2) ? (ya | yb) : (ys ? yb : ya);
      if (yy && m_ones < BL) m_ones++;
      if (CHK && yy != (ys ? yb : ya)) begin
        m_mm = 1'b1;
        if (m_mmc < BL) m_mmc++;
      end
      pos++;
    end else if (bus.result_ready) begin
      pos = -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",           bus.busy,           int'(pos != -1));
      check("result_valid",   bus.result_valid,   int'(pos == BL));
      check("a",              bus.a,              int'(m_a()));
      check("b",              bus.b,              int'(m_b()));
      check("rand_bit",       bus.rand_bit,       int'(m_r()));
      check("ones_count",     bus.ones_count,     m_ones);
      check("mismatch",       bus.mismatch,       int'(m_mm));
      check("mismatch_count", bus.mismatch_count, m_mmc);
    end
  end

  task automatic do_run(input logic [7:0] av, input logic [7:0] bv, input int flt,
                        input int hold, output int ones_out, output int mm_out,
                        output int mmc_out);
    int n;
    fault = flt;
    bus.a_val = av;
    bus.b_val = bv;
    bus.result_ready = (hold == 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.result_valid && n < BL + 8) begin
      bus.start = ($urandom_range(0, 15) == 0);
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("valid_latency", n, BL);
    ones_out = bus.ones_count;
    mm_out   = bus.mismatch;
    mmc_out  = bus.mismatch_count;
    for (int i = 0; i < hold; i++) begin
      bus.start = (i % 2 == 0);
      tick();
      check("hold_ones",  bus.ones_count, ones_out);
      check("hold_valid", bus.result_valid, 1);
    end
    bus.result_ready = 1'b1;
    bus.start = (hold > 0);
    tick();
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    check("idle_after_handshake", bus.busy, 0);
    check("ones_retained", bus.ones_count, ones_out);
  endtask

  initial begin : stim
    logic [7:0] va, vb, vs;
    int r1, r2, ref_ones, mm, mmc;
    va = SA; vb = SB; vs = SS;
    for (int i = 0; i < BL; i++) begin
      seq_a[i] = va; seq_b[i] = vb; seq_s[i] = vs;
      va = lfsr_step(va); vb = lfsr_step(vb); vs = lfsr_step(vs);
    end
    check("model_lfsr_a1", seq_a[1], 8'h4A);

    bus.start = 1'b0; bus.a_val = '0; bus.b_val = '0; bus.result_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busy",  bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_ones",  bus.ones_count, 0);
    rst = 1'b0;
    tick();

    // Zero probabilities: no 1s, no mismatch.
    do_run(8'h00, 8'h00, 0, 0, r1, mm, mmc);
    check("zero_ones", r1, 0);
    check("zero_mismatch", mm, 0);

    // Held result with start pulses in DONE.
    do_run(8'h80, 8'h80, 0, 20, r1, mm, mmc);

    // Stuck-at-1 adder.
    do_run(8'h00, 8'h00, 1, 3, r1, mm, mmc);
    check("stuck_ones", r1, BL);
    check("model_stuck_ones", m_ones, BL);
    check("stuck_mismatch", mm, CHK ? 1 : 0);
    check("stuck_mismatch_count", mmc, CHK ? BL : 0);

    // Uninterrupted reference, then a run reset at bit 50, then a rerun.
    do_run(8'h90, 8'h30, 0, 1, ref_ones, mm, mmc);
    fault = 0;
    bus.a_val = 8'h90; bus.b_val = 8'h30; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",  bus.busy, 0);
    check("midrst_a",     bus.a, 0);
    check("midrst_b",     bus.b, 0);
    check("midrst_rand",  bus.rand_bit, 0);
    check("midrst_ones",  bus.ones_count, 0);
    check("midrst_valid", bus.result_valid, 0);
    do_run(8'h90, 8'h30, 0, 0, r1, mm, mmc);
    check("rerun_after_rst", r1, ref_ones);

    // Back-to-back identical runs.
    do_run(8'h40, 8'hC0, 0, 0, r1, mm, mmc);
    do_run(8'h40, 8'hC0, 0, 0, r2, mm, mmc);
    check("back_to_back", r2, r1);

    // Randomized runs, including a faulty OR-gate adder.
    for (int k = 0; k < 8; k++) begin
      do_run(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 5)), r1, mm, mmc);
      repeat ($urandom_range(0, 4)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
